// File: rtl/sr_fifo_uart_tx_pkg.sv
// ---------------------------------------------------------------------------
// sr_fifo_uart_tx_pkg
// Shared definitions for the CPU push-path UART transmitter:
//   - default geometry (entry count, pointer width, clocks per UART bit)
//   - the 2-bit transmitter state encoding
//   - a helper that picks the low or high byte of a stored word
// ---------------------------------------------------------------------------
package sr_fifo_uart_tx_pkg;

  localparam int WORD_W          = 16;
  localparam int UTX_DEPTH_DEF   = 8;
  localparam int UTX_ADDR_W_DEF  = 3;
  localparam int UTX_CLK_DIV_DEF = 16;

  typedef enum logic [1:0] {
    UTX_IDLE  = 2'd0,
    UTX_START = 2'd1,
    UTX_DATA  = 2'd2,
    UTX_STOP  = 2'd3
  } utx_state_e;

  // sel=0 returns the low byte (sent first), sel=1 the high byte.
  function automatic logic [7:0] word_byte(input logic [WORD_W-1:0] w, input logic sel);
    return sel ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/sr_fifo_uart_tx_if.sv
// ---------------------------------------------------------------------------
// sr_fifo_uart_tx_if
// Push-side bus of the transmit FIFO.
//   push, din              : producer -> FIFO (write request and data word)
//   full, empty, level     : FIFO -> producer (occupancy)
//   overflow               : FIFO -> producer (sticky dropped-write flag)
// master = producer (CPU side), slave = sr_fifo_uart_tx.
// ---------------------------------------------------------------------------
interface sr_fifo_uart_tx_if
  import sr_fifo_uart_tx_pkg::*;
#(
  parameter int ADDR_W = UTX_ADDR_W_DEF
);

  logic              push;
  logic [WORD_W-1:0] din;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              overflow;

  modport master (
    output push, din,
    input  full, empty, level, overflow
  );

  modport slave (
    input  push, din,
    output full, empty, level, overflow
  );

endinterface

// File: rtl/sr_fifo_mem.sv
// ---------------------------------------------------------------------------
// sr_fifo_mem
// DEPTH x WIDTH synchronous FIFO: storage array, read/write pointers and an
// explicit occupancy counter. Written to be reusable on a receive path.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (pointers/level only)
//   push, din  : write request and data
//   pop, dout  : read request; dout shows the oldest entry combinationally
//   full/empty : derived from level
//   level      : number of stored entries, 0..DEPTH
// A push while full is still taken when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module sr_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              wr_en, rd_en;

  always_comb begin
    rd_en = pop && (level_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    wr_en = push && ((level_q != FULL_LEVEL) || rd_en);
    // DEPTH is a power of two, so pointer wrap is plain modular overflow.
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
    level_d  = level_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once level is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/sr_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// sr_fifo_uart_tx
// Consumer end of the CPU push path. Buffers 16-bit words and sends each as
// two UART 8N1 frames (low byte first) on a registered tx line.
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of sr_fifo_uart_tx_if (push/din in; full, empty,
//              level, sticky overflow out)
//   busy     : transmitter is not idle
//   tx       : UART line, idle high, driven straight from a flop
// ---------------------------------------------------------------------------
module sr_fifo_uart_tx
  import sr_fifo_uart_tx_pkg::*;
#(
  parameter int DEPTH   = UTX_DEPTH_DEF,
  parameter int ADDR_W  = UTX_ADDR_W_DEF,
  parameter int CLK_DIV = UTX_CLK_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_fifo_uart_tx_if.slave     bus,
  output logic                 busy,
  output logic                 tx
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  utx_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              byte_sel_q, byte_sel_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        hold_q, hold_d;     // high byte of the word in flight
  logic              overflow_q, overflow_d;
  logic              tx_q, tx_d;

  logic              pop;
  logic              bit_done;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  sr_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.push),
    .pop   (pop),
    .din   (bus.din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (bus.level)
  );

  assign bit_done = (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = bit_done ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    byte_sel_d = byte_sel_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    pop        = 1'b0;

    unique case (state_q)
      UTX_IDLE: begin
        div_cnt_d = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = word_byte(fifo_dout, 1'b0);
          hold_d     = word_byte(fifo_dout, 1'b1);
          byte_sel_d = 1'b0;
          state_d    = UTX_START;
        end
      end
      UTX_START: begin
        if (bit_done) begin
          bit_cnt_d = '0;
          state_d   = UTX_DATA;
        end
      end
      UTX_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = UTX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      UTX_STOP: begin
        if (bit_done) begin
          if (!byte_sel_q) begin
            shift_d    = hold_q;
            byte_sel_d = 1'b1;
            state_d    = UTX_START;
          end else if (!fifo_empty) begin
            // Next word loads straight into START: no idle bit between words.
            pop        = 1'b1;
            shift_d    = word_byte(fifo_dout, 1'b0);
            hold_d     = word_byte(fifo_dout, 1'b1);
            byte_sel_d = 1'b0;
            state_d    = UTX_START;
          end else begin
            state_d = UTX_IDLE;
          end
        end
      end
      default: state_d = UTX_IDLE;
    endcase

    // tx reflects the state held during the previous cycle, so the line
    // changes one clock after the state register does.
    unique case (state_q)
      UTX_START: tx_d = 1'b0;
      UTX_DATA:  tx_d = shift_q[0];
      default:   tx_d = 1'b1;
    endcase

    overflow_d = overflow_q | (bus.push & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UTX_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      byte_sel_q <= 1'b0;
      shift_q    <= '0;
      hold_q     <= '0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_sel_q <= byte_sel_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;
  assign busy         = (state_q != UTX_IDLE);
  assign tx           = tx_q;

endmodule

// File: tb/tb_sr_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_sr_fifo_uart_tx
// Reference model works at word/frame level: a queue of accepted words, the
// edge at which each word was taken by the transmitter, and the rule that a
// word occupies exactly 20 bit times. The expected tx level on every cycle is
// derived from the frame bit pattern of the word in flight.
// ---------------------------------------------------------------------------
module tb_sr_fifo_uart_tx;

  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 3;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 20 * CLK_DIV;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic tx;

  sr_fifo_uart_tx_if #(.ADDR_W(ADDR_W)) bus ();

  sr_fifo_uart_tx #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state.
  logic [15:0] q[$];
  bit          m_busy;
  bit          m_ovf;
  bit          cur_v, prev_v;
  int          cur_load, prev_load;
  logic [15:0] cur_word, prev_word;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Bit b (0..19) of the two-frame sequence for word w.
  function automatic logic frame_bit(input logic [15:0] w, input int b);
    int   k;
    logic [7:0] by;
    k  = b % 10;
    by = (b < 10) ? w[7:0] : w[15:8];
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return by[k-1];
  endfunction

  // The line trails the transmitter's load edge by one clock.
  function automatic logic exp_tx();
    int off;
    if (cur_v) begin
      off = cyc - cur_load - 1;
      if (off >= 0 && off < FRAME) return frame_bit(cur_word, off / CLK_DIV);
    end
    if (prev_v) begin
      off = cyc - prev_load - 1;
      if (off >= 0 && off < FRAME) return frame_bit(prev_word, off / CLK_DIV);
    end
    return 1'b1;
  endfunction

  task automatic model_edge(input bit p, input logic [15:0] d, input bit r, output bit acc);
    bit pop;
    acc = 1'b0;
    if (r) begin
      q.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      cur_v  = 1'b0;
      prev_v = 1'b0;
      return;
    end
    pop = (q.size() > 0) && (!m_busy || cyc == cur_load + FRAME);
    if (m_busy && cyc == cur_load + FRAME && !pop) m_busy = 1'b0;
    if (pop) begin
      prev_v    = cur_v;
      prev_load = cur_load;
      prev_word = cur_word;
      cur_v     = 1'b1;
      cur_load  = cyc;
      cur_word  = q.pop_front();
      m_busy    = 1'b1;
    end
    if (p) begin
      if (q.size() < DEPTH) begin
        q.push_back(d);
        acc = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check_val("level",    32'(bus.level),    32'(q.size()));
    check_val("full",     32'(bus.full),     32'(q.size() == DEPTH));
    check_val("empty",    32'(bus.empty),    32'(q.size() == 0));
    check_val("overflow", 32'(bus.overflow), 32'(m_ovf));
    check_val("busy",     32'(busy),         32'(m_busy));
    check_val("tx",       32'(tx),           32'(exp_tx()));
  endtask

  task automatic tick(input bit p, input logic [15:0] d, input bit r);
    bit acc;
    bus.push = p;
    bus.din  = d;
    rst      = r;
    @(posedge clk);
    cyc++;
    model_edge(p, d, r, acc);
    #1;
    if (p && !r)
      $display("push cyc=%0d din=%04h %s level=%0d", cyc, d, acc ? "accepted" : "dropped", q.size());
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 16'h0000, 1'b1);
  endtask

  initial begin
    bus.push = 1'b0;
    bus.din  = '0;
    rst      = 1'b1;
    m_busy = 0; m_ovf = 0; cur_v = 0; prev_v = 0;
    cur_load = 0; prev_load = 0; cur_word = '0; prev_word = '0;

    // Quiet line after reset.
    do_reset(3);
    idle(100);

    // Single word A55A: start bit, 0x5A, stop, start, 0xA5, stop.
    tick(1'b1, 16'hA55A, 1'b0);
    idle(1);
    check_val("busy_after_load", 32'(busy), 32'd1);
    idle(1);
    check_val("tx_start_fall", 32'(tx), 32'd0);
    idle(100);
    check_val("busy_done", 32'(busy), 32'd0);

    // Fill behind a word in flight: eighth push fills, ninth is dropped.
    do_reset(2);
    tick(1'b1, 16'h1111, 1'b0);
    idle(2);
    for (int i = 1; i <= 9; i++) begin
      tick(1'b1, 16'(i), 1'b0);
      if (i == 8) check_val("full_after_8", 32'(bus.full), 32'd1);
    end
    check_val("ovf_after_9", 32'(bus.overflow), 32'd1);
    idle(9 * FRAME + 20);

    // Push while full on the very edge the transmitter pops.
    do_reset(2);
    tick(1'b1, 16'h2222, 1'b0);
    for (int i = 1; i <= 8; i++) tick(1'b1, 16'h0100 + 16'(i), 1'b0);
    for (int i = 0; i < 2 * FRAME && (cyc + 1) != (cur_load + FRAME); i++) idle(1);
    tick(1'b1, 16'h0BEE, 1'b0);
    check_val("full_pop_level", 32'(bus.level), 32'd8);
    check_val("full_pop_ovf", 32'(bus.overflow), 32'd0);
    tick(1'b1, 16'h0C0D, 1'b0);
    check_val("full_nopop_ovf", 32'(bus.overflow), 32'd1);
    idle(9 * FRAME + 20);

    // Reset in the middle of a data bit.
    do_reset(1);
    tick(1'b1, 16'h1234, 1'b0);
    idle(20);
    do_reset(1);
    check_val("rst_mid_tx", 32'(tx), 32'd1);
    check_val("rst_mid_level", 32'(bus.level), 32'd0);
    idle(50);
    tick(1'b1, 16'h00FF, 1'b0);
    idle(100);

    // Randomized traffic with bursty push rates and rare resets.
    begin
      int rate;
      rate = 10;
      for (int i = 0; i < 3000; i++) begin
        if (i % 250 == 0) rate = int'($urandom_range(0, 60));
        if ($urandom_range(0, 1499) == 0)
          tick(1'b0, 16'h0000, 1'b1);
        else
          tick(($urandom_range(0, 99) < rate), 16'($urandom), 1'b0);
      end
    end
    idle(DEPTH * FRAME + 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
